fpcvt_pipe: RTL
===============

// Module: fpcvt_pipe
// PURPOSE
//  Parametrised, pipelined two's-complement to sign/exponent/mantissa float converter.
//  Streams one sample per clock through a valid/ready interface.
//  3 stages: sign-magnitude -> leading-one encode -> round/saturate.
//  Output value = (-1)^S * F * 2^E; defaults reproduce the 12-bit -> S/E3/F4 format.
// PARAMETERS
//  IN_W   12  input two's-complement width
//  EXP_W  3   exponent width; E max = 2^EXP_W-1
//  MAN_W  4   mantissa width (leading one kept explicitly in F)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data valid this cycle
//  in_ready   out  1      converter accepts in_data this cycle
//  in_data    in   IN_W   two's-complement sample
//  out_valid  out  1      out_s/out_e/out_f valid
//  out_ready  in   1      downstream accepts result
//  out_s      out  1      sign
//  out_e      out  EXP_W  exponent
//  out_f      out  MAN_W  mantissa
//  out_sat    out  1      result was clamped to max magnitude
// BEHAVIOUR
//  - Reset: all stage valids 0; out_valid=0, out_s=0, out_e=0, out_f=0, out_sat=0.
//    Reset mid-stream flushes every stage; in-flight samples are lost.
//  - adv = !out_valid | out_ready; in_ready = adv (combinational).
//    All 3 stages shift when adv=1, all hold when adv=0.
//  - Transfer on in_valid & in_ready. Latency exactly 3 cycles when unstalled.
//    Throughput 1/clk. Bubbles propagate as valid=0.
//  - Outputs stable while out_valid & !out_ready.
//  - Stage 1: S = msb; M = |in_data| on IN_W bits (most-negative gives 2^(IN_W-1)).
//  - Stage 2: L = bit length of M (0 for M=0); E0 = max(0, L-MAN_W);
//    F0 = M[E0+MAN_W-1:E0]; R = M[E0-1] if E0>0, else 0.
//  - Stage 3: round half-up: F1 = F0+R.
//    If F1 overflows MAN_W bits: F = 1<<(MAN_W-1), E = E0+1.
//    If E > 2^EXP_W-1: E = all ones, F = all ones, out_sat = 1.
//    Sign passes unchanged, including -0 impossibility: in_data=0 gives S0 E0 F0.
//  - Width rule: E0 computed on clog2(IN_W+1) bits before clamp; no wrap permitted.
// CONFIGURATION
//  FPCVT_SAT_CNT_EN defined:
//    - Adds output sat_cnt [15:0].
//    - Increments once per transferred result (out_valid & out_ready) with out_sat=1.
//    - Saturates at 16'hFFFF; reset to 0 by rst.
//  FPCVT_SAT_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package fpcvt_pkg: default widths, E_MAX = 2^EXP_W-1, LZ_W = clog2(IN_W+1).
//  Sub-module fpcvt_lead_enc (combinational): M -> E0, F0, R, parametrised;
//  used inside stage 2. Stage regs and handshake stay in fpcvt_pipe.
// TESTING (defaults IN_W=12, EXP_W=3, MAN_W=4; out_ready=1 unless stated)
//  1. in_data=0 -> 3 clks later S0 E0 F0 sat0; -1 (12'hFFF) -> S1 E0 F1.
//  2. 422 -> S0 E5 F13 (trunc); 125 -> S0 E4 F8 (round overflow into exponent).
//  3. 2047 -> S0 E7 F15 sat1; -2048 (12'h800) -> S1 E7 F15 sat1.
//  4. Back-to-back stream 0..4095 with random out_ready:
//     in-order, no drops/dups, outputs held while stalled, matches reference model.
//  5. Assert rst with 3 samples in flight:
//     out_valid drops immediately, no stale output after release, next sample 3 clks later.
//  6. FPCVT_SAT_CNT_EN: 5 saturating samples, one held 4 stall cycles -> sat_cnt=5.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared defaults and width helpers for the fpcvt_pipe two's-complement to float converter.
//   IN_W_D/EXP_W_D/MAN_W_D : default input, exponent and mantissa widths (12 -> S/E3/F4)
//   E_MAX                  : largest exponent for the default format
//   LZ_W                   : width of the unclamped exponent for the default input width
//   lz_w()                 : same width for any input width
package fpcvt_pkg;
    localparam int IN_W_D = 12;
    localparam int EXP_W_D = 3;
    localparam int MAN_W_D = 4;
    localparam int E_MAX = 2**EXP_W_D - 1;
    localparam int LZ_W = $clog2(IN_W_D + 1);
    function automatic int lz_w(input int in_w);
        return $clog2(in_w + 1);
    endfunction
endpackage

// File: rtl/fpcvt_if.sv
// fpcvt_if: valid/ready stream bundle for fpcvt_pipe.
//   in_valid/in_ready/in_data                 : sample input channel
//   out_valid/out_ready/out_s/out_e/out_f/out_sat : result output channel
//   slave modport for the converter, master modport for the producer/consumer side
interface fpcvt_if
    import fpcvt_pkg::*;
#(
    parameter int IN_W = IN_W_D,
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D
);
    logic in_valid;
    logic in_ready;
    logic [IN_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic out_s;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_f;
    logic out_sat;
    modport slave(input in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_s, out_e, out_f, out_sat);
    modport master(output in_valid, in_data, out_ready,
                   input in_ready, out_valid, out_s, out_e, out_f, out_sat);
endinterface

// File: rtl/fpcvt_lead_enc.sv
// fpcvt_lead_enc: combinational leading-one encoder for fpcvt_pipe stage 2.
//   m  : unsigned magnitude
//   e0 : unclamped exponent max(0, bitlen(m) - MAN_W)
//   f0 : MAN_W bits of m starting at e0
//   r  : bit just below f0 (rounding bit), 0 when e0 = 0
module fpcvt_lead_enc
    import fpcvt_pkg::*;
#(
    parameter int IN_W = IN_W_D,
    parameter int MAN_W = MAN_W_D,
    parameter int LZW = lz_w(IN_W)
) (
    input  logic [IN_W-1:0]  m,
    output logic [LZW-1:0]   e0,
    output logic [MAN_W-1:0] f0,
    output logic             r
);
    logic [LZW-1:0] len;
    always_comb begin
        len = '0;
        for (int i = 0; i < IN_W; i++)
            if (m[i]) len = LZW'(i + 1);
        e0 = (len > LZW'(MAN_W)) ? len - LZW'(MAN_W) : '0;
        // the appended zero makes the rounding bit fall out of the same shift, and read 0 when e0 = 0
        {f0, r} = (MAN_W + 1)'({m, 1'b0} >> e0);
    end
endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage pipelined two's-complement -> sign/exponent/mantissa converter, value = (-1)^S * F * 2^E.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, flushes all stages
//   bus     : fpcvt_if.slave stream (in_valid/in_ready/in_data, out_valid/out_ready/out_s/out_e/out_f/out_sat)
//   sat_cnt : saturated-result counter, present only when FPCVT_SAT_CNT_EN is defined
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W = IN_W_D,
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D
) (
    input logic clk,
    input logic rst,
    fpcvt_if.slave bus
`ifdef FPCVT_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);
    localparam int LZW = lz_w(IN_W);
    localparam int EMAX = 2**EXP_W - 1;
    logic adv;
    logic v1, s1, v2, s2, r2, r0, sat;
    logic [IN_W-1:0] m1;
    logic [LZW-1:0] e0, e2;
    logic [MAN_W-1:0] f0, f2, f;
    logic [MAN_W:0] f1;
    logic [LZW:0] e1;
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    fpcvt_lead_enc #(.IN_W(IN_W), .MAN_W(MAN_W), .LZW(LZW)) u_enc (.m(m1), .e0(e0), .f0(f0), .r(r0));
    // a rounding carry out of the mantissa leaves 1000..0 in f1[MAN_W:1] and bumps the exponent
    assign f1 = {1'b0, f2} + (MAN_W + 1)'(r2);
    assign e1 = {1'b0, e2} + (LZW + 1)'(f1[MAN_W]);
    assign f = f1[MAN_W] ? f1[MAN_W:1] : f1[MAN_W-1:0];
    assign sat = int'(e1) > EMAX;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            m1 <= '0;
            v2 <= 1'b0;
            s2 <= 1'b0;
            e2 <= '0;
            f2 <= '0;
            r2 <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_s <= 1'b0;
            bus.out_e <= '0;
            bus.out_f <= '0;
            bus.out_sat <= 1'b0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            s1 <= bus.in_data[IN_W-1];
            // negating the most-negative code yields 100..0, read as unsigned 2^(IN_W-1)
            m1 <= bus.in_data[IN_W-1] ? -bus.in_data : bus.in_data;
            v2 <= v1;
            s2 <= s1;
            e2 <= e0;
            f2 <= f0;
            r2 <= r0;
            bus.out_valid <= v2;
            bus.out_s <= s2;
            bus.out_e <= sat ? '1 : EXP_W'(e1);
            bus.out_f <= sat ? '1 : f;
            bus.out_sat <= sat;
        end
    end
`ifdef FPCVT_SAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
`endif
endmodule
